song_player: RTL and testbench
==============================

Name: song_player

Overview:
- Memory-port-B reader that plays a song stored in data memory.
- The CPU writes note words through port A; this block fetches them sequentially through Address_B/data_b.
- Each word is turned into a square-wave tone on a speaker output for a programmed number of beats.
- Sits beside the CPU and shares the dual-port RAM, driving port B (read-only).

Parameters:
- BASE_ADDR, 16'h0100, port-B address of the first note word of the song.
- SONG_LEN_MAX, 256, maximum number of note words; the address offset wraps modulo this value.
- BEAT_CYCLES, 32'd12500000, clock cycles per beat.
- TONE_PRESCALE, 16'd50, clock cycles per half-period unit.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Song_Select  in  1  level; high = play, low = stop/abort
- Address_B  out  16  memory port B read address
- data_b  in  16  memory port B read data, valid 1 cycle after Address_B
- speaker  out  1  square-wave tone output
- playing  out  1  high while in FETCH/WAIT/PLAY
- note_index  out  8  offset of the current note word
- song_done  out  1  high in DONE

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-high, named reset.
- Reset values:
  - state=IDLE
  - Address_B=BASE_ADDR
  - speaker=0, playing=0, song_done=0, note_index=0
  - all counters 0
- Note word format:
  - [15:12] = duration in beats; 0 = end-of-song marker.
  - [11:0] = half-period in TONE_PRESCALE units; 0 = rest (speaker held 0).
- States:
  - IDLE: Song_Select=1 -> FETCH; note_index=0, Address_B=BASE_ADDR.
  - FETCH: Address_B = BASE_ADDR + note_index (registered). Next cycle -> WAIT.
  - WAIT: capture data_b into the note register (1-cycle RAM latency).
    - Duration 0 -> DONE.
    - Otherwise -> PLAY; load beat_cnt=duration, cycle_cnt=0, tone_cnt=0, speaker=0.
  - PLAY:
    - cycle_cnt increments each clock. At BEAT_CYCLES-1 it clears and beat_cnt decrements.
    - When beat_cnt would reach 0: note_index increments, with wrap to 0 at SONG_LEN_MAX-1 -> FETCH.
    - Tone: tone_cnt counts to half_period*TONE_PRESCALE-1, then speaker toggles and tone_cnt clears.
    - The product is computed at 28 bits, with no overflow for the 12-bit × 16-bit operands.
  - DONE: song_done=1, speaker=0. Song_Select=0 -> IDLE.
- Note timing: exactly duration*BEAT_CYCLES clocks in PLAY per note. Inter-note gap is 2 clocks (FETCH+WAIT) with speaker=0.
- Abort: Song_Select=0 in any non-IDLE state -> IDLE next clock; speaker=0, playing=0, counters cleared. Re-assertion restarts from note 0.
- Reset mid-note forces the reset values immediately (asynchronous).
- Wrap: note_index reaching SONG_LEN_MAX-1 without an end marker wraps to 0 and playback continues.
- Address_B changes only on FETCH entry. Port B is never written.

Optional Feature:
- Macro: SONG_PLAYER_LOOP_EN.
- Defined: an end-of-song marker in WAIT returns to FETCH with note_index=0, so the song loops forever until Song_Select=0. song_done stays 0.
- Undefined: the end marker -> DONE as above.

Decomposition:
- Shared package / include: state encoding constants (IDLE, FETCH, WAIT, PLAY, DONE), note-word field positions (DUR_MSB/LSB, HP_MSB/LSB), END_MARKER=4'h0.
- One natural sub-module, tone_divider: prescaled half-period counter plus speaker toggle, with enable and clear.
- The FSM, beat counter and address logic stay in song_player.

Test Plan:
All cases use BEAT_CYCLES=4, TONE_PRESCALE=1, BASE_ADDR=16'h0100, and a RAM model with 1-cycle latency.
- Note words {16'h2003, 16'h0000}, Song_Select=1:
  - Address_B=0x0100 then 0x0101.
  - speaker toggles every 3 clocks for 8 clocks of PLAY.
  - song_done=1 after reading 0x0101; playing=0.
- Rest word 16'h1000: speaker stays 0 for 4 clocks while playing=1.
- Abort: Song_Select dropped at PLAY cycle 3 of word 16'h3002 -> next clock state=IDLE, speaker=0. Reassertion fetches 0x0100 again.
- Reset asserted mid-PLAY -> outputs equal the reset values in the same cycle, without waiting for a clock edge.
- Wrap: SONG_LEN_MAX=4, all words 16'h1001 -> Address_B sequence 0x0100, 0x0101, 0x0102, 0x0103, 0x0100.
- With SONG_PLAYER_LOOP_EN, words {16'h1001, 16'h0000} -> Address_B alternates 0x0100, 0x0101, 0x0100; song_done never 1.

Source files
------------

// File: rtl/song_player_pkg.sv
// -----------------------------------------------------------------------------
// song_player_pkg
// Shared definitions for the song player: FSM state encoding, note-word field
// positions, the end-of-song marker value and the tone half-period helper.
// No ports (package).
// -----------------------------------------------------------------------------
package song_player_pkg;

  // Player FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Note word layout: [15:12] duration in beats, [11:0] half-period units
  localparam int DUR_MSB = 15;
  localparam int DUR_LSB = 12;
  localparam int HP_MSB  = 11;
  localparam int HP_LSB  = 0;

  // A zero duration marks the end of the song
  localparam logic [3:0] END_MARKER = 4'h0;

  // Half-period length in clocks; 28 bits hold any 12-bit x 16-bit product
  function automatic logic [27:0] tone_cycles(input logic [11:0] half_period,
                                              input logic [15:0] prescale);
    return {16'd0, half_period} * {12'd0, prescale};
  endfunction

endpackage

// File: rtl/song_player_tone_divider.sv
// -----------------------------------------------------------------------------
// song_player_tone_divider
// Prescaled half-period counter driving a square-wave speaker output.
// The speaker toggles every half_period*TONE_PRESCALE enabled clocks; a zero
// half-period is a rest and holds the speaker low.
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous active-high reset
//   i_en           count enable (note is playing)
//   i_clr          synchronous clear of counter and speaker (has priority)
//   i_half_period  half-period in prescale units, 0 = rest
//   o_speaker      registered square-wave output
// -----------------------------------------------------------------------------
module song_player_tone_divider
  import song_player_pkg::*;
#(
  parameter logic [15:0] TONE_PRESCALE = 16'd50
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [11:0] i_half_period,
  output logic        o_speaker
);

  logic [27:0] r_tone_cnt;
  logic        r_speaker;
  logic [27:0] w_limit;
  logic        w_rest;

  assign w_limit   = tone_cycles(i_half_period, TONE_PRESCALE) - 28'd1;
  assign w_rest    = (i_half_period == 12'd0);
  assign o_speaker = r_speaker;

  // Half-period counter and speaker toggle
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tone_cnt <= 28'd0;
      r_speaker  <= 1'b0;
    end else if (i_clr) begin
      r_tone_cnt <= 28'd0;
      r_speaker  <= 1'b0;
    end else if (i_en && !w_rest) begin
      if (r_tone_cnt >= w_limit) begin
        r_tone_cnt <= 28'd0;
        r_speaker  <= ~r_speaker;
      end else begin
        r_tone_cnt <= r_tone_cnt + 28'd1;
      end
    end else begin
      r_tone_cnt <= 28'd0;
      r_speaker  <= 1'b0;
    end
  end

endmodule

// File: rtl/song_player.sv
// -----------------------------------------------------------------------------
// song_player
// Reads note words from memory port B (read-only, 1-cycle latency) starting at
// BASE_ADDR and plays each as a square-wave tone for duration*BEAT_CYCLES
// clocks. A zero-duration word ends the song.
// Build option: define SONG_PLAYER_LOOP_EN to make the end marker restart the
// song from note 0 instead of stopping in DONE.
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset
//   Song_Select  level: 1 = play, 0 = stop/abort
//   Address_B    port B read address (changes only on FETCH entry)
//   data_b       port B read data, valid one cycle after Address_B
//   speaker      square-wave tone output
//   playing      high in FETCH/WAIT/PLAY
//   note_index   offset of the current note word
//   song_done    high in DONE
// -----------------------------------------------------------------------------
module song_player
  import song_player_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = 16'h0100,
  parameter int unsigned SONG_LEN_MAX  = 256,
  parameter logic [31:0] BEAT_CYCLES   = 32'd12500000,
  parameter logic [15:0] TONE_PRESCALE = 16'd50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Song_Select,
  output logic [15:0] Address_B,
  input  logic [15:0] data_b,
  output logic        speaker,
  output logic        playing,
  output logic [7:0]  note_index,
  output logic        song_done
);

  localparam logic [7:0]  LAST_INDEX = 8'(SONG_LEN_MAX - 1);
  localparam logic [31:0] BEAT_LAST  = BEAT_CYCLES - 32'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_addr;
  logic [7:0]  r_index;
  logic [7:0]  w_index_next;
  logic [7:0]  w_index_inc;
  logic [3:0]  r_beat_cnt;
  logic [31:0] r_cycle_cnt;
  logic [11:0] r_half_period;
  logic        r_playing;
  logic        r_done;
  logic        w_cycle_last;
  logic        w_note_end;
  logic        w_fetch_entry;
  logic        w_tone_en;
  logic        w_tone_clr;
  logic [3:0]  w_duration;

  assign w_duration    = data_b[DUR_MSB:DUR_LSB];
  assign w_cycle_last  = (r_cycle_cnt == BEAT_LAST);
  // Last clock of the last beat of the current note
  assign w_note_end    = w_cycle_last && (r_beat_cnt == 4'd1);
  assign w_index_inc   = (r_index == LAST_INDEX) ? 8'd0 : (r_index + 8'd1);
  assign w_fetch_entry = (w_state_next == ST_FETCH) && (r_state != ST_FETCH);

  // Tone runs only while staying in PLAY; clearing on entry and exit keeps the
  // speaker low through the FETCH/WAIT gap.
  assign w_tone_en  = (r_state == ST_PLAY);
  assign w_tone_clr = (r_state != ST_PLAY) || (w_state_next != ST_PLAY);

  assign Address_B  = r_addr;
  assign playing    = r_playing;
  assign note_index = r_index;
  assign song_done  = r_done;

  // Next-state and next note index
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    case (r_state)
      ST_IDLE: begin
        if (Song_Select) begin
          w_state_next = ST_FETCH;
          w_index_next = 8'd0;
        end else begin
          w_state_next = ST_IDLE;
          w_index_next = 8'd0;
        end
      end
      ST_FETCH: begin
        if (!Song_Select) begin
          w_state_next = ST_IDLE;
          w_index_next = 8'd0;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!Song_Select) begin
          w_state_next = ST_IDLE;
          w_index_next = 8'd0;
        end else if (w_duration == END_MARKER) begin
`ifdef SONG_PLAYER_LOOP_EN
          w_state_next = ST_FETCH;
          w_index_next = 8'd0;
`else
          w_state_next = ST_DONE;
`endif
        end else begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!Song_Select) begin
          w_state_next = ST_IDLE;
          w_index_next = 8'd0;
        end else if (w_note_end) begin
          w_state_next = ST_FETCH;
          w_index_next = w_index_inc;
        end else begin
          w_state_next = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (!Song_Select) begin
          w_state_next = ST_IDLE;
          w_index_next = 8'd0;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_index_next = 8'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address, note index, beat/cycle counters and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr        <= BASE_ADDR;
      r_index       <= 8'd0;
      r_beat_cnt    <= 4'd0;
      r_cycle_cnt   <= 32'd0;
      r_half_period <= 12'd0;
      r_playing     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_index <= w_index_next;
      if (w_fetch_entry) begin
        r_addr <= BASE_ADDR + {8'd0, w_index_next};
      end
      r_playing <= (w_state_next == ST_FETCH) || (w_state_next == ST_WAIT) ||
                   (w_state_next == ST_PLAY);
      r_done    <= (w_state_next == ST_DONE);
      if ((r_state == ST_WAIT) && (w_state_next == ST_PLAY)) begin
        r_beat_cnt    <= w_duration;
        r_cycle_cnt   <= 32'd0;
        r_half_period <= data_b[HP_MSB:HP_LSB];
      end else if ((r_state == ST_PLAY) && (w_state_next == ST_PLAY)) begin
        if (w_cycle_last) begin
          r_cycle_cnt <= 32'd0;
          r_beat_cnt  <= r_beat_cnt - 4'd1;
        end else begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
      end else begin
        r_beat_cnt    <= 4'd0;
        r_cycle_cnt   <= 32'd0;
        r_half_period <= 12'd0;
      end
    end
  end

  song_player_tone_divider #(
    .TONE_PRESCALE (TONE_PRESCALE)
  ) u_tone (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_en          (w_tone_en),
    .i_clr         (w_tone_clr),
    .i_half_period (r_half_period),
    .o_speaker     (speaker)
  );

endmodule

// File: tb/tb_song_player.sv
// -----------------------------------------------------------------------------
// tb_song_player
// Directed and randomized checks of song_player against a cycle-timeline
// reference built from the note words (2-clock fetch gap, duration*beat clocks
// of tone, speaker level from the elapsed PLAY clock count).
// -----------------------------------------------------------------------------
module tb_song_player;

  localparam logic [15:0] BASE = 16'h0100;
  localparam int LEN  = 4;
  localparam int BEAT = 4;
  localparam int PRE  = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        Song_Select;
  logic [15:0] Address_B;
  logic [15:0] data_b;
  logic        speaker;
  logic        playing;
  logic [7:0]  note_index;
  logic        song_done;

  logic [15:0] mem [0:255];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic        spk;
    logic        ply;
    logic        done;
    logic [7:0]  idx;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] last_addr;

  song_player #(
    .BASE_ADDR     (BASE),
    .SONG_LEN_MAX  (LEN),
    .BEAT_CYCLES   (32'd4),
    .TONE_PRESCALE (16'd1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .Song_Select (Song_Select),
    .Address_B   (Address_B),
    .data_b      (data_b),
    .speaker     (speaker),
    .playing     (playing),
    .note_index  (note_index),
    .song_done   (song_done)
  );

  always #5 clock = ~clock;

  // 1-cycle latency RAM, port B read
  always @(posedge clock) data_b <= mem[Address_B[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input bit spk, input bit ply, input bit done);
    exp_t e;
    e.addr = BASE + 16'(idx);
    e.spk  = spk;
    e.ply  = ply;
    e.done = done;
    e.idx  = 8'(idx);
    expq.push_back(e);
  endtask

  // Expected per-clock outputs from the first Song_Select edge onward
  task automatic build(input int ncyc);
    int idx;
    int dur;
    int hp;
    logic [15:0] w;
    expq.delete();
    idx = 0;
    while (expq.size() < ncyc) begin
      push(idx, 1'b0, 1'b1, 1'b0);
      push(idx, 1'b0, 1'b1, 1'b0);
      w   = mem[idx];
      dur = int'(w[15:12]);
      hp  = int'(w[11:0]);
      if (dur == 0) begin
`ifdef SONG_PLAYER_LOOP_EN
        idx = 0;
`else
        while (expq.size() < ncyc) push(idx, 1'b0, 1'b0, 1'b1);
`endif
      end else begin
        for (int k = 0; k < dur * BEAT; k++)
          push(idx, (hp == 0) ? 1'b0 : 1'((k / (hp * PRE)) % 2), 1'b1, 1'b0);
        idx = (idx + 1) % LEN;
      end
    end
  endtask

  task automatic play(input int ncyc, input string tag);
    build(ncyc);
    @(negedge clock);
    Song_Select = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("%s.c%0d.addr", tag, i), 32'(Address_B), 32'(expq[i].addr));
      chk($sformatf("%s.c%0d.spk", tag, i), 32'(speaker), 32'(expq[i].spk));
      chk($sformatf("%s.c%0d.ply", tag, i), 32'(playing), 32'(expq[i].ply));
      chk($sformatf("%s.c%0d.done", tag, i), 32'(song_done), 32'(expq[i].done));
      chk($sformatf("%s.c%0d.idx", tag, i), 32'(note_index), 32'(expq[i].idx));
      last_addr = expq[i].addr;
    end
  endtask

  // Drop Song_Select and confirm the idle outputs one clock later
  task automatic drop(input string tag);
    Song_Select = 1'b0;
    @(posedge clock);
    #1;
    chk({tag, ".stop.ply"}, 32'(playing), 32'd0);
    chk({tag, ".stop.spk"}, 32'(speaker), 32'd0);
    chk({tag, ".stop.done"}, 32'(song_done), 32'd0);
    chk({tag, ".stop.idx"}, 32'(note_index), 32'd0);
    chk({tag, ".stop.addr"}, 32'(Address_B), 32'(last_addr));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"}, 32'(Address_B), 32'(BASE));
    chk({tag, ".spk"}, 32'(speaker), 32'd0);
    chk({tag, ".ply"}, 32'(playing), 32'd0);
    chk({tag, ".done"}, 32'(song_done), 32'd0);
    chk({tag, ".idx"}, 32'(note_index), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset       = 1'b1;
    Song_Select = 1'b0;
    #1;
    chk_reset_vals("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Two-word song: 2 beats of half-period 3, then end marker
    mem[0] = 16'h2003;
    mem[1] = 16'h0000;
    play(16, "basic");
    drop("basic");

    // Rest note: speaker held low while playing
    mem[0] = 16'h1000;
    mem[1] = 16'h0000;
    play(10, "rest");
    drop("rest");

    // Abort after PLAY cycle 3, then restart from note 0
    mem[0] = 16'h3002;
    mem[1] = 16'h0000;
    play(6, "abort");
    drop("abort");
    play(4, "restart");
    drop("restart");

    // Asynchronous reset in the middle of the second note
    mem[0] = 16'h1001;
    mem[1] = 16'h2002;
    mem[2] = 16'h0000;
    play(11, "midrst");
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst.rst");
    Song_Select = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Wrap: no end marker within SONG_LEN_MAX words
    for (int i = 0; i < LEN; i++) mem[i] = 16'h1001;
    play(32, "wrap");
    drop("wrap");

    // Loop/stop behaviour on the end marker
    mem[0] = 16'h1001;
    mem[1] = 16'h0000;
    play(18, "endmark");
    drop("endmark");

    // Randomized songs
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < LEN; j++)
        mem[j] = {4'($urandom_range(0, 3)), 12'($urandom_range(0, 5))};
      play(int'($urandom_range(20, 50)), $sformatf("rand%0d", r));
      drop($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
